// File: rtl/bram_simple_dual_port.sv
// Simple dual-port block RAM: one write port, one read port, one clock.
// Read latency 1-3 with a valid pipeline, byte-lane writes, collision policy.
module bram_simple_dual_port #(
  parameter int    mem_width        = 32,
  parameter int    mem_depth        = 4096,
  parameter int    read_latency     = 2,
  parameter string byte_write_mode  = "false",
  parameter string collision_mode   = "forward",
  parameter string INIT_FILE        = "no_init",
  parameter int    simulation_delay = 1,
  localparam int   WL = (byte_write_mode == "true") ? mem_width / 8 : 1,
  localparam int   AW = $clog2(mem_depth - 1) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WL-1:0]        wen,
  input  logic [AW-1:0]        waddr,
  input  logic [mem_width-1:0] din,
  input  logic                 ren,
  input  logic [AW-1:0]        raddr,
  output logic [mem_width-1:0] dout,
  output logic                 dout_vld
);

  localparam bit BYTE_MODE = (byte_write_mode == "true");
  localparam bit FWD       = (collision_mode == "forward");
  localparam int IW        = (mem_depth > 1) ? $clog2(mem_depth) : 1;

  if (read_latency < 1 || read_latency > 3) begin : g_bad_lat
    $error("read_latency must be 1, 2 or 3");
  end
  if (BYTE_MODE && (mem_width % 8 != 0)) begin : g_bad_width
    $error("mem_width must be a multiple of 8 in byte mode");
  end
  if (simulation_delay < 0) begin : g_bad_dly
    $error("simulation_delay must be non-negative");
  end

  typedef logic [mem_width-1:0] mem_t [mem_depth];

  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < mem_depth; i++) begin
      m[i] = (INIT_FILE == "default") ? mem_width'(i) : '0;
    end
    return m;
  endfunction

  mem_t mem = mem_init();

  logic [mem_width-1:0] wmask;
  logic [mem_width-1:0] rd_old;
  logic [mem_width-1:0] rd_word;
  logic                 w_hit;
  logic                 r_hit;
  logic                 coll;
  logic [IW-1:0]        widx;
  logic [IW-1:0]        ridx;

  if (BYTE_MODE) begin : g_byte
    for (genvar k = 0; k < WL; k++) begin : g_lane
      assign wmask[k*8 +: 8] = {8{wen[k]}};
    end
  end else begin : g_word
    assign wmask = {mem_width{wen[0]}};
  end

  assign widx = waddr[IW-1:0];
  assign ridx = raddr[IW-1:0];

  always_comb begin
    w_hit   = (|wen) && (32'(waddr) < mem_depth);
    r_hit   = 32'(raddr) < mem_depth;
    coll    = w_hit && (waddr == raddr);
    rd_old  = r_hit ? mem[ridx] : '0;
    rd_word = rd_old;
    // Forwarding merges only the lanes being written this edge.
    if (FWD && coll) begin
      rd_word = (rd_old & ~wmask) | (din & wmask);
    end
  end

  always_ff @(posedge clk) begin
    if (w_hit) begin
      mem[widx] <= (mem[widx] & ~wmask) | (din & wmask);
    end
  end

  logic [read_latency-1:0] vld_d;
  logic [read_latency-1:0] vld_q;
  logic [mem_width-1:0]    dat_d [read_latency];
  logic [mem_width-1:0]    dat_q [read_latency];

  always_comb begin
    vld_d[0] = ren;
    dat_d[0] = ren ? rd_word : dat_q[0];
    for (int i = 1; i < read_latency; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < read_latency; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign dout     = dat_q[read_latency-1];
  assign dout_vld = vld_q[read_latency-1];

endmodule

// File: tb/tb_bram_simple_dual_port.sv
// Directed bench for bram_simple_dual_port across three configurations.
// a: L=2 byte/forward, b: L=3 depth 100 old_data, c: L=1 word/forward.
module tb_bram_simple_dual_port;

  logic        clk;
  logic        rst;
  logic        ren;
  logic [12:0] waddr;
  logic [12:0] raddr;
  logic [31:0] din;
  logic [3:0]  wen_a;
  logic        wen_b;
  logic        wen_c;
  logic [31:0] dout_a;
  logic [31:0] dout_b;
  logic [31:0] dout_c;
  logic        vld_a;
  logic        vld_b;
  logic        vld_c;

  int checks;
  int failures;
  logic [31:0] exp_b [100];

  bram_simple_dual_port #(
    .mem_width(32), .mem_depth(4096), .read_latency(2),
    .byte_write_mode("true"), .collision_mode("forward"),
    .INIT_FILE("default"), .simulation_delay(1)
  ) u_a (
    .clk(clk), .rst(rst), .wen(wen_a), .waddr(waddr),
    .din(din), .ren(ren), .raddr(raddr),
    .dout(dout_a), .dout_vld(vld_a)
  );

  bram_simple_dual_port #(
    .mem_width(32), .mem_depth(100), .read_latency(3),
    .byte_write_mode("false"), .collision_mode("old_data"),
    .INIT_FILE("default"), .simulation_delay(1)
  ) u_b (
    .clk(clk), .rst(rst), .wen(wen_b), .waddr(waddr[7:0]),
    .din(din), .ren(ren), .raddr(raddr[7:0]),
    .dout(dout_b), .dout_vld(vld_b)
  );

  bram_simple_dual_port #(
    .mem_width(32), .mem_depth(4096), .read_latency(1),
    .byte_write_mode("false"), .collision_mode("forward"),
    .INIT_FILE("default"), .simulation_delay(1)
  ) u_c (
    .clk(clk), .rst(rst), .wen(wen_c), .waddr(waddr),
    .din(din), .ren(ren), .raddr(raddr),
    .dout(dout_c), .dout_vld(vld_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren   = 1'b0;
    wen_a = 4'h0;
    wen_b = 1'b0;
    wen_c = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    idle();
    waddr = '0;
    raddr = '0;
    din   = '0;
    cyc();
    cyc();
    rst = 1'b0;
    checks++;
    if (dout_a !== 32'h0 || vld_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_a dout=%h vld=%b want 0/0", dout_a, vld_a);
    end
    checks++;
    if (dout_b !== 32'h0 || vld_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_b dout=%h vld=%b want 0/0", dout_b, vld_b);
    end
    checks++;
    if (dout_c !== 32'h0 || vld_c !== 1'b0) begin
      failures++;
      $display("FAIL reset_c dout=%h vld=%b want 0/0", dout_c, vld_c);
    end
  endtask

  task automatic test_back_to_back();
    int lat [3];
    lat = '{2, 3, 1};
    for (int t = 0; t < 12; t++) begin
      ren   = (t < 8);
      raddr = 13'(t);
      cyc();
      for (int d = 0; d < 3; d++) begin
        int          k;
        logic [31:0] od;
        logic        ov;
        logic [31:0] ed;
        logic        ev;
        k  = t - lat[d] + 1;
        od = (d == 0) ? dout_a : (d == 1) ? dout_b : dout_c;
        ov = (d == 0) ? vld_a : (d == 1) ? vld_b : vld_c;
        if (k < 0) begin
          ev = 1'b0;
          ed = 32'h0;
        end else if (k < 8) begin
          ev = 1'b1;
          ed = 32'(k);
        end else begin
          ev = 1'b0;
          ed = 32'h7;
        end
        checks++;
        if (od !== ed || ov !== ev) begin
          failures++;
          $display("FAIL b2b dut=%0d t=%0d dout=%h vld=%b want %h/%b",
                   d, t, od, ov, ed, ev);
        end
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    wen_a = 4'hF;
    waddr = 13'd5;
    din   = 32'hDEADBEEF;
    cyc();
    idle();
    cyc();
    ren   = 1'b1;
    raddr = 13'd5;
    cyc();
    idle();
    checks++;
    if (vld_a !== 1'b0 || dout_a !== 32'h7) begin
      failures++;
      $display("FAIL wr_early dout=%h vld=%b want 00000007/0",
               dout_a, vld_a);
    end
    cyc();
    checks++;
    if (vld_a !== 1'b1 || dout_a !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_data dout=%h vld=%b want deadbeef/1",
               dout_a, vld_a);
    end
    cyc();
    checks++;
    if (vld_a !== 1'b0 || dout_a !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_hold dout=%h vld=%b want deadbeef/0",
               dout_a, vld_a);
    end
  endtask

  task automatic test_byte_write();
    wen_a = 4'hF;
    waddr = 13'd3;
    din   = 32'h11223344;
    cyc();
    wen_a = 4'b0101;
    din   = 32'hAABBCCDD;
    cyc();
    idle();
    ren   = 1'b1;
    raddr = 13'd3;
    cyc();
    idle();
    cyc();
    checks++;
    if (vld_a !== 1'b1 || dout_a !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL byte_wr dout=%h vld=%b want 11bb33dd/1",
               dout_a, vld_a);
    end
  endtask

  task automatic test_collision();
    wen_a = 4'hF;
    wen_b = 1'b1;
    waddr = 13'd7;
    din   = 32'h0;
    cyc();
    din   = 32'h12345678;
    ren   = 1'b1;
    raddr = 13'd7;
    cyc();
    idle();
    exp_b[7] = 32'h12345678;
    cyc();
    checks++;
    if (vld_a !== 1'b1 || dout_a !== 32'h12345678) begin
      failures++;
      $display("FAIL coll_fwd dout=%h vld=%b want 12345678/1",
               dout_a, vld_a);
    end
    cyc();
    checks++;
    if (vld_b !== 1'b1 || dout_b !== 32'h0) begin
      failures++;
      $display("FAIL coll_old dout=%h vld=%b want 00000000/1",
               dout_b, vld_b);
    end
    checks++;
    if (vld_a !== 1'b0) begin
      failures++;
      $display("FAIL coll_pulse vld_a=%b want 0", vld_a);
    end
    ren   = 1'b1;
    raddr = 13'd7;
    cyc();
    idle();
    cyc();
    checks++;
    if (vld_a !== 1'b1 || dout_a !== 32'h12345678) begin
      failures++;
      $display("FAIL coll_after_a dout=%h vld=%b want 12345678/1",
               dout_a, vld_a);
    end
    cyc();
    checks++;
    if (vld_b !== 1'b1 || dout_b !== 32'h12345678) begin
      failures++;
      $display("FAIL coll_after_b dout=%h vld=%b want 12345678/1",
               dout_b, vld_b);
    end
  endtask

  task automatic test_reset_in_flight();
    wen_b = 1'b1;
    waddr = 13'd9;
    din   = 32'hCAFEF00D;
    cyc();
    idle();
    ren   = 1'b1;
    raddr = 13'd9;
    cyc();
    cyc();
    rst   = 1'b1;
    wen_b = 1'b1;
    waddr = 13'd10;
    din   = 32'h00000077;
    cyc();
    rst = 1'b0;
    idle();
    exp_b[10] = 32'h00000077;
    checks++;
    if (vld_b !== 1'b0 || dout_b !== 32'h0) begin
      failures++;
      $display("FAIL rst_flight dout=%h vld=%b want 0/0", dout_b, vld_b);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (vld_b !== 1'b0 || dout_b !== 32'h0) begin
        failures++;
        $display("FAIL rst_drop cyc=%0d dout=%h vld=%b want 0/0",
                 i, dout_b, vld_b);
      end
    end
    wen_b = 1'b1;
    waddr = 13'd9;
    din   = 32'h5A5A1234;
    cyc();
    idle();
    exp_b[9] = 32'h5A5A1234;
    ren   = 1'b1;
    raddr = 13'd9;
    cyc();
    idle();
    cyc();
    cyc();
    checks++;
    if (vld_b !== 1'b1 || dout_b !== 32'h5A5A1234) begin
      failures++;
      $display("FAIL rst_rewrite dout=%h vld=%b want 5a5a1234/1",
               dout_b, vld_b);
    end
    ren   = 1'b1;
    raddr = 13'd10;
    cyc();
    idle();
    cyc();
    cyc();
    checks++;
    if (vld_b !== 1'b1 || dout_b !== 32'h00000077) begin
      failures++;
      $display("FAIL rst_same_edge_wr dout=%h vld=%b want 00000077/1",
               dout_b, vld_b);
    end
  endtask

  task automatic test_out_of_range();
    wen_b = 1'b1;
    waddr = 13'd120;
    din   = 32'hFFFFFFFF;
    cyc();
    idle();
    ren   = 1'b1;
    raddr = 13'd120;
    cyc();
    idle();
    cyc();
    cyc();
    checks++;
    if (vld_b !== 1'b1 || dout_b !== 32'h0) begin
      failures++;
      $display("FAIL oor_read dout=%h vld=%b want 00000000/1",
               dout_b, vld_b);
    end
    for (int t = 0; t < 102; t++) begin
      ren   = (t < 100);
      raddr = 13'(t);
      cyc();
      if (t >= 2) begin
        checks++;
        if (vld_b !== 1'b1 || dout_b !== exp_b[t-2]) begin
          failures++;
          $display("FAIL oor_sweep addr=%0d dout=%h vld=%b want %h/1",
                   t - 2, dout_b, vld_b, exp_b[t-2]);
        end
      end
    end
    idle();
    cyc();
    checks++;
    if (vld_b !== 1'b0) begin
      failures++;
      $display("FAIL oor_end vld=%b want 0", vld_b);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 100; i++) begin
      exp_b[i] = 32'(i);
    end
    test_reset();
    test_back_to_back();
    test_write_read();
    test_byte_write();
    test_collision();
    test_reset_in_flight();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
